// File: rtl/hilo_if.sv
// HI/LO unit bus: MT/MF controls, mul/div request, and result/status outputs.
interface hilo_if;
    logic        hilowrite;
    logic        hilodst;
    logic        hilosrc;
    logic [31:0] wdata;
    logic        op_start;
    logic [1:0]  op_sel;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic [31:0] rdata;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy;
    logic        done;

    modport master (
        output hilowrite, hilodst, hilosrc, wdata, op_start, op_sel, src_a, src_b, flush,
        input  rdata, hi_o, lo_o, busy, done
    );
    modport slave (
        input  hilowrite, hilodst, hilosrc, wdata, op_start, op_sel, src_a, src_b, flush,
        output rdata, hi_o, lo_o, busy, done
    );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO registers with single-cycle-latched multiply and a 32-step restoring divider.
// Define HILO_DIV_EN to build the divider (DIV/FIX states); otherwise DIV/DIVU are ignored.
module hilo_unit (
    input  logic   clk,
    input  logic   resetn,
    hilo_if.slave  bus
);
`ifdef HILO_DIV_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;
`else
    typedef enum logic [1:0] {IDLE, MUL} state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [63:0] prod_q, prod_d;
    logic        done_q, done_d;

    logic        accept, is_signed;
    logic [63:0] a_ext, b_ext, prod_full;

    assign is_signed = ~bus.op_sel[0];
`ifdef HILO_DIV_EN
    assign accept = bus.op_start && !bus.flush && (state_q == IDLE);
`else
    assign accept = bus.op_start && !bus.flush && (state_q == IDLE) && !bus.op_sel[1];
`endif
    assign a_ext     = {{32{is_signed & bus.src_a[31]}}, bus.src_a};
    assign b_ext     = {{32{is_signed & bus.src_b[31]}}, bus.src_b};
    assign prod_full = a_ext * b_ext;

`ifdef HILO_DIV_EN
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic        negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;
    logic [32:0] rem_sh, diff;

    // Remainder shifted left with the next dividend bit; dividend bits drain out of quo_q's top.
    assign rem_sh = {rem_q, quo_q[31]};
    assign diff   = rem_sh - {1'b0, dvs_q};
`endif

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        prod_d  = prod_q;
        done_d  = 1'b0;
`ifdef HILO_DIV_EN
        cnt_d  = cnt_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        negq_d = negq_q;
        negr_d = negr_q;
        dz_d   = dz_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!bus.op_sel[1]) begin
                        prod_d  = prod_full;
                        state_d = MUL;
                    end
`ifdef HILO_DIV_EN
                    else begin
                        quo_d   = (is_signed && bus.src_a[31]) ? -bus.src_a : bus.src_a;
                        dvs_d   = (is_signed && bus.src_b[31]) ? -bus.src_b : bus.src_b;
                        rem_d   = 32'd0;
                        negq_d  = is_signed & (bus.src_a[31] ^ bus.src_b[31]);
                        negr_d  = is_signed & bus.src_a[31];
                        cnt_d   = 5'd0;
                        dz_d    = (bus.src_b == 32'd0);
                        state_d = (bus.src_b == 32'd0) ? FIX : DIV;
                    end
`endif
                end else if (bus.hilowrite && !bus.flush) begin
                    if (bus.hilodst) hi_d = bus.wdata;
                    else             lo_d = bus.wdata;
                end
            end
            MUL: begin
                state_d = IDLE;
                if (!bus.flush) begin
                    hi_d   = prod_q[63:32];
                    lo_d   = prod_q[31:0];
                    done_d = 1'b1;
                end
            end
`ifdef HILO_DIV_EN
            DIV: begin
                if (bus.flush) begin
                    state_d = IDLE;
                    cnt_d   = 5'd0;
                end else begin
                    if (!diff[32]) begin
                        rem_d = diff[31:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[31:0];
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                cnt_d   = 5'd0;
                if (!bus.flush) begin
                    done_d = 1'b1;
                    if (!dz_q) begin
                        lo_d = negq_q ? -quo_q : quo_q;
                        hi_d = negr_q ? -rem_q : rem_q;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            prod_q  <= 64'd0;
            done_q  <= 1'b0;
`ifdef HILO_DIV_EN
            cnt_q   <= 5'd0;
            quo_q   <= 32'd0;
            rem_q   <= 32'd0;
            dvs_q   <= 32'd0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
`ifdef HILO_DIV_EN
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
`endif
        end
    end

    assign bus.rdata = bus.hilosrc ? hi_q : lo_q;
    assign bus.hi_o  = hi_q;
    assign bus.lo_o  = lo_q;
    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = done_q;
endmodule

// File: doc/hilo_unit.md
# hilo_unit

HI/LO register file plus iterative multiply/divide engine for the MIPS core. Sits directly downstream of the main decoder, which supplies the MTHI/MTLO/MFHI/MFLO control bits. Owns the architectural HI and LO registers, executes MULT/MULTU/DIV/DIVU as multi-cycle operations, and raises `busy` so the hazard logic stalls the pipeline until results land.

## Interface
Parameters:
- none.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `hilowrite`  in  1  MTHI/MTLO write request, decoder-generated.
- `hilodst`  in  1  write target: 1 = HI, 0 = LO.
- `hilosrc`  in  1  read select for `rdata`: 1 = HI, 0 = LO.
- `wdata`  in  32  rs value for MTHI/MTLO.
- `op_start`  in  1  start a mul/div operation.
- `op_sel`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `src_a`, `src_b`  in  32 each  rs (dividend/multiplicand), rt (divisor/multiplier).
- `flush`  in  1  exception flush; cancels in-flight operation.
- `rdata`  out  32  `hilosrc ? HI : LO`, combinational from current registers.
- `hi_o`, `lo_o`  out  32 each  current HI, LO.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  registered one-cycle pulse after a mul/div result is written.

## Operation
- States: IDLE, MUL, DIV, FIX. Reset: HI = LO = 0, state IDLE, iteration counter 0, `busy` = 0, `done` = 0.
- `op_start` is accepted only in IDLE with `flush` low; otherwise ignored.
- MULT/MULTU: accept edge latches the 64-bit product (signed or unsigned per `op_sel`) into an internal register → MUL. Next edge: HI = product[63:32], LO = product[31:0], → IDLE, `done` = 1.
- DIV/DIVU, divisor nonzero: accept edge latches operand magnitudes (signed) or raw values (unsigned), result signs, counter = 0 → DIV. One restoring shift-subtract iteration per edge; after the 32nd → FIX. FIX edge: apply signs, LO = quotient, HI = remainder, → IDLE, `done` = 1.
- Signed divide: quotient truncates toward zero; remainder takes sign of dividend. 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- Divide by zero: accept edge → FIX directly. FIX edge writes nothing (HI/LO unchanged), still pulses `done`.
- `hilowrite` in IDLE: writes `wdata` to HI or LO per `hilodst` on the next edge. It is ignored when state != IDLE, when `flush` is high, or when `op_start` is accepted in the same cycle (the op wins).
- `flush` in any non-IDLE state: next edge → IDLE, counter cleared, HI/LO unchanged, no `done`.
- Async reset mid-operation: immediate return to reset values; the partial result is discarded.

## Timing
- Writes by `hilowrite` are visible on `rdata`/`hi_o`/`lo_o` the cycle after the write edge. There is no same-cycle bypass; the forwarding unit handles that.
- MULT: `busy` high 1 cycle; result visible 2 edges after the accept edge.
- DIV nonzero: `busy` high 33 cycles (32 DIV + 1 FIX); result visible 34 edges after the accept edge.
- Divide by zero: `busy` high 1 cycle.
- `done` is high for exactly the first IDLE cycle following a completing MUL or FIX.
- The decoder's `hilowrite` arriving in the `done` cycle is legal and writes normally, overwriting the just-written result.

## Configuration
- `HILO_DIV_EN` defined: DIV/DIVU supported as above; DIV and FIX states and the divider datapath are present.
- Not defined: the divider and the DIV/FIX states are compiled out. `op_start` with `op_sel` 10/11 is ignored: no `busy`, no `done`, HI/LO unchanged. MULT/MULTU and MT/MF behaviour are unaffected.

## Test plan
- Reset, then MTHI 0x12345678 and MTLO 0x9ABCDEF0 → `hi_o` = 0x12345678, `lo_o` = 0x9ABCDEF0; `rdata` follows `hilosrc`.
- MULT 0xFFFFFFFE × 0x00000003 → after 2 edges HI = 0xFFFFFFFF, LO = 0xFFFFFFFA; `busy` high 1 cycle; `done` pulses once. MULTU with the same operands → HI = 0x00000002, LO = 0xFFFFFFFA.
- DIV 0xFFFFFFF9 (−7) / 2 → `busy` 33 cycles; LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 100 / 7 → LO = 14, HI = 2.
- DIV by 0 with HI/LO preloaded to 0xAAAA/0x5555 → `busy` 1 cycle, `done` pulse, HI/LO unchanged.
- Start DIVU, assert `flush` at iteration 10 → IDLE next edge, no `done`, HI/LO unchanged. Then `hilowrite` while busy, and `hilowrite` together with `op_start` in IDLE → both writes are dropped.
- Build without `HILO_DIV_EN`: DIV request → `busy` stays 0, no `done`; MULT still yields correct HI/LO.
